rifl_tx_sched: RTL and testbench

- Per-frame-slot scheduler on the TX side; one frame type is chosen each slot.
- Candidate frame types: idle, user data, replayed frame, pause request, retransmission request.
- Consumes the RX-side event flags (link_up, rx_up, rx_error, pause_req, retrans_req) and drives the user data handshake and the replay buffer read/rewind controls.
- Sits in the tx_frame_clk domain, between the user TX interface, the replay buffer and the TX frame encoder.

---
 rtl/rifl_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_rifl_tx_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rifl_tx_sched.sv
// -----------------------------------------------------------------------------
// rifl_tx_sched
//   Per-frame-slot TX scheduler. Each cycle the encoder offers a slot
//   (frame_slot), exactly one frame type is chosen: IDLE, user DATA, REPLAY
//   from the replay buffer, PAUSE request or RETRANS_REQ. The choice is
//   reported one cycle later on frame_type/frame_type_vld, while the user and
//   replay-buffer handshakes fire combinationally in the slot cycle itself.
//
// Ports
//   clk            tx_frame_clk
//   rst            synchronous active-high reset
//   frame_slot     encoder takes one frame this cycle
//   link_up        link established (level); low forces INIT immediately
//   rx_up          local RX can accept; falling edge requests a peer PAUSE
//   rx_error       pulse, local RX saw a bad frame -> request retransmission
//   pause_req      level, peer asks us to stop data/replay
//   retrans_req    pulse, peer asks for retransmission -> rewind + REPLAY
//   user_vld       user TX frame available
//   user_rdy       user frame consumed this cycle
//   replay_vld     replay buffer has a frame at its read pointer
//   replay_rd      replay frame consumed this cycle
//   replay_rewind  pulse, reset replay read pointer to oldest unacked frame
//   frame_type     0 IDLE, 1 DATA, 2 REPLAY, 3 PAUSE, 4 RETRANS_REQ
//   frame_type_vld frame_type valid (one cycle after frame_slot)
// -----------------------------------------------------------------------------
module rifl_tx_sched #(
   parameter int FRAME_ID_WIDTH  = 8,
   parameter int RETRANS_HOLDOFF = 16,
   parameter int PAUSE_REFRESH   = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_slot,
   input  logic       link_up,
   input  logic       rx_up,
   input  logic       rx_error,
   input  logic       pause_req,
   input  logic       retrans_req,
   input  logic       user_vld,
   output logic       user_rdy,
   input  logic       replay_vld,
   output logic       replay_rd,
   output logic       replay_rewind,
   output logic [2:0] frame_type,
   output logic       frame_type_vld
);

   // Replay buffer depth is 2**(FRAME_ID_WIDTH+1); the scheduler only needs
   // the vld/rd/rewind handshake, so the width is checked but not used.
   if (FRAME_ID_WIDTH < 1 || RETRANS_HOLDOFF < 1 || PAUSE_REFRESH < 1) begin : g_param_chk
      $error("rifl_tx_sched: parameters must be >= 1");
   end

   localparam int HW = $clog2(RETRANS_HOLDOFF) + 1;
   localparam int PW = $clog2(PAUSE_REFRESH) + 1;

   localparam logic [HW-1:0] HOLD_LOAD = HW'(RETRANS_HOLDOFF);
   localparam logic [PW-1:0] REF_LAST  = PW'(PAUSE_REFRESH - 1);

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_NORMAL = 2'd1;
   localparam logic [1:0] ST_REPLAY = 2'd2;

   localparam logic [2:0] FT_IDLE   = 3'd0;
   localparam logic [2:0] FT_DATA   = 3'd1;
   localparam logic [2:0] FT_REPLAY = 3'd2;
   localparam logic [2:0] FT_PAUSE  = 3'd3;
   localparam logic [2:0] FT_RTX    = 3'd4;

   logic [1:0]    state;
   logic          rtx_pend;
   logic          pse_pend;
   logic [HW-1:0] hold_cnt;
   logic [PW-1:0] ref_cnt;
   logic          rx_up_q;
   logic          rewind_q;

   logic          active;
   logic [2:0]    sel;
   logic          sent_rtx;
   logic          sent_pse;
   logic          rx_fall;
   logic          ref_hit;

   // Link down takes effect in the same cycle, before the state register
   // catches up.
   assign active = link_up && (state != ST_INIT);

   // Slot arbitration uses only pre-event flags; events seen this cycle
   // influence the next slot.
   always_comb begin
      sel = FT_IDLE;
      if (!active)                sel = FT_IDLE;
      else if (rtx_pend)          sel = FT_RTX;
      else if (pse_pend)          sel = FT_PAUSE;
      else if (pause_req)         sel = FT_IDLE;
      else if (state == ST_REPLAY)
         // No read in the rewind cycle: the read pointer is being reset.
         sel = (replay_vld && !rewind_q) ? FT_REPLAY : FT_IDLE;
      else
         sel = user_vld ? FT_DATA : FT_IDLE;
   end

   assign user_rdy      = frame_slot && (sel == FT_DATA);
   assign replay_rd     = frame_slot && (sel == FT_REPLAY);
   assign replay_rewind = rewind_q && link_up;

   assign sent_rtx = frame_slot && (sel == FT_RTX);
   assign sent_pse = frame_slot && (sel == FT_PAUSE);
   assign rx_fall  = rx_up_q && !rx_up;
   // Refresh fires on the PAUSE_REFRESH-th slot counted since the last
   // fall/refresh while rx_up stays low.
   assign ref_hit  = frame_slot && !rx_up && !rx_fall && (ref_cnt == REF_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_INIT;
         rtx_pend       <= 1'b0;
         pse_pend       <= 1'b0;
         hold_cnt       <= '0;
         ref_cnt        <= '0;
         rx_up_q        <= 1'b1;
         rewind_q       <= 1'b0;
         frame_type     <= FT_IDLE;
         frame_type_vld <= 1'b0;
      end else begin
         frame_type_vld <= frame_slot;
         if (frame_slot) frame_type <= sel;

         if (!active) begin
            // INIT: everything cleared. rx_up_q is parked high so that a
            // peer still needing a pause gets one as soon as we go NORMAL.
            state    <= link_up ? ST_NORMAL : ST_INIT;
            rtx_pend <= 1'b0;
            pse_pend <= 1'b0;
            hold_cnt <= '0;
            ref_cnt  <= '0;
            rx_up_q  <= 1'b1;
            rewind_q <= 1'b0;
         end else begin
            rx_up_q  <= rx_up;
            rewind_q <= retrans_req;

            case (state)
               ST_NORMAL: if (retrans_req) state <= ST_REPLAY;
               ST_REPLAY: if (frame_slot && !replay_vld && !retrans_req && !rewind_q)
                             state <= ST_NORMAL;
               default:   state <= ST_NORMAL;
            endcase

            // Retransmission request with holdoff; errors arriving while a
            // request is pending or holdoff is running are merged.
            if (rx_error && !rtx_pend && (hold_cnt == '0))
               rtx_pend <= 1'b1;
            else if (sent_rtx)
               rtx_pend <= 1'b0;

            if (sent_rtx)
               hold_cnt <= HOLD_LOAD;
            else if (frame_slot && (hold_cnt != '0))
               hold_cnt <= hold_cnt - HW'(1);

            // Pause request: on the falling edge and periodically while low.
            if (rx_fall || ref_hit)
               pse_pend <= 1'b1;
            else if (sent_pse)
               pse_pend <= 1'b0;

            if (rx_up || rx_fall || ref_hit)
               ref_cnt <= '0;
            else if (frame_slot)
               ref_cnt <= ref_cnt + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rifl_tx_sched.sv
module tb_rifl_tx_sched;
   localparam int HOLD = 16;
   localparam int PREF = 64;

   logic clk = 1'b0;
   logic rst, frame_slot, link_up, rx_up, rx_error, pause_req, retrans_req;
   logic user_vld, user_rdy, replay_vld, replay_rd, replay_rewind;
   logic [2:0] frame_type;
   logic frame_type_vld;

   always #5 clk = ~clk;

   rifl_tx_sched #(.FRAME_ID_WIDTH(8), .RETRANS_HOLDOFF(HOLD), .PAUSE_REFRESH(PREF)) dut (
      .clk(clk), .rst(rst), .frame_slot(frame_slot), .link_up(link_up), .rx_up(rx_up),
      .rx_error(rx_error), .pause_req(pause_req), .retrans_req(retrans_req),
      .user_vld(user_vld), .user_rdy(user_rdy), .replay_vld(replay_vld),
      .replay_rd(replay_rd), .replay_rewind(replay_rewind),
      .frame_type(frame_type), .frame_type_vld(frame_type_vld));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural reference model ---------------------------------------
   // Holdoff and pause refresh are tracked by slot index arithmetic
   // (slots elapsed since an event) rather than down/up counters.
   int m_st;          // 0 init, 1 normal, 2 replay
   bit m_rtx, m_pse, m_rxq, m_rew, m_ftv, have_rtx;
   int m_ft, n_slots, last_rtx, pse_ref;

   int s_urdy, s_rrd, s_rew, s_ft, s_ftv;
   int slot_urdy, slot_rrd, slot_ft;

   task automatic model_reset();
      m_st = 0; m_rtx = 0; m_pse = 0; m_rxq = 1; m_rew = 0; m_ftv = 0; m_ft = 0;
      have_rtx = 0; n_slots = 0; last_rtx = 0; pse_ref = 0;
   endtask

   task automatic cyc();
      int sel;
      bit busy, hz, fall, trig, nrtx;
      @(negedge clk);
      #4;
      s_urdy = user_rdy; s_rrd = replay_rd; s_rew = replay_rewind;
      s_ft = frame_type; s_ftv = frame_type_vld;
      if (rst) model_reset();
      else begin
         busy = !link_up || m_st == 0;
         sel = 0;
         if (busy) sel = 0;
         else if (m_rtx) sel = 4;
         else if (m_pse) sel = 3;
         else if (pause_req) sel = 0;
         else if (m_st == 2) sel = (replay_vld && !m_rew) ? 2 : 0;
         else sel = user_vld ? 1 : 0;
         chk("mdl_user_rdy", s_urdy, (frame_slot && sel == 1) ? 1 : 0);
         chk("mdl_replay_rd", s_rrd, (frame_slot && sel == 2) ? 1 : 0);
         chk("mdl_replay_rewind", s_rew, (m_rew && link_up) ? 1 : 0);
         chk("mdl_frame_type_vld", s_ftv, int'(m_ftv));
         chk("mdl_frame_type", s_ft, m_ft);
         if (frame_slot) m_ft = sel;
         m_ftv = frame_slot;
         if (busy) begin
            m_st = link_up ? 1 : 0;
            m_rtx = 0; m_pse = 0; have_rtx = 0; m_rxq = 1; m_rew = 0;
         end else begin
            hz = !have_rtx || (n_slots - 1 - last_rtx) >= HOLD;
            nrtx = m_rtx;
            if (frame_slot && sel == 4) begin nrtx = 0; have_rtx = 1; last_rtx = n_slots; end
            if (rx_error && hz && !m_rtx) nrtx = 1;
            fall = m_rxq && !rx_up;
            trig = 0;
            if (fall) begin
               pse_ref = frame_slot ? n_slots : n_slots - 1;
               trig = 1;
            end else if (!rx_up && frame_slot && (n_slots - pse_ref) == PREF) begin
               trig = 1;
               pse_ref = n_slots;
            end
            if (trig) m_pse = 1;
            else if (frame_slot && sel == 3) m_pse = 0;
            m_rtx = nrtx;
            m_rxq = rx_up;
            if (m_st == 1 && retrans_req) m_st = 2;
            else if (m_st == 2 && frame_slot && !replay_vld && !retrans_req && !m_rew) m_st = 1;
            m_rew = retrans_req;
         end
         if (frame_slot) n_slots++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      frame_slot = 0; link_up = 0; rx_up = 1; rx_error = 0; pause_req = 0;
      retrans_req = 0; user_vld = 0; replay_vld = 0;
   endtask

   task automatic do_reset();
      rst = 1; clr_in();
      cyc(); cyc();
      chk("reset_user_rdy", s_urdy, 0);
      chk("reset_replay_rd", s_rrd, 0);
      chk("reset_rewind", s_rew, 0);
      chk("reset_frame_type", s_ft, 0);
      chk("reset_frame_type_vld", s_ftv, 0);
      rst = 0;
   endtask

   // one slot cycle then one gap cycle; pulses are cleared after the slot
   task automatic do_slot();
      frame_slot = 1;
      cyc();
      slot_urdy = s_urdy; slot_rrd = s_rrd;
      frame_slot = 0; rx_error = 0; retrans_req = 0;
      cyc();
      slot_ft = s_ft;
      chk("slot_ftv", s_ftv, 1);
   endtask

   typedef struct packed {
      logic lk, sl, uv, rv, rt, re, pq;
      logic urdy, rrd, rew;
      logic [2:0] ft;
      logic ftv;
   } vec_t;
   vec_t tbl [15];

   int cnt, exp_ft;

   initial begin
      //            lk    sl    uv    rv    rt    re    pq    urdy  rrd   rew   ft    ftv
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

      model_reset();
      do_reset();

      // ---- table-driven vectors from reset ----
      for (int i = 0; i < 15; i++) begin
         link_up = tbl[i].lk; frame_slot = tbl[i].sl; user_vld = tbl[i].uv;
         replay_vld = tbl[i].rv; retrans_req = tbl[i].rt; rx_error = tbl[i].re;
         pause_req = tbl[i].pq; rx_up = 1;
         cyc();
         chk($sformatf("tbl%0d_user_rdy", i), s_urdy, int'(tbl[i].urdy));
         chk($sformatf("tbl%0d_replay_rd", i), s_rrd, int'(tbl[i].rrd));
         chk($sformatf("tbl%0d_rewind", i), s_rew, int'(tbl[i].rew));
         chk($sformatf("tbl%0d_frame_type", i), s_ft, int'(tbl[i].ft));
         chk($sformatf("tbl%0d_ftv", i), s_ftv, int'(tbl[i].ftv));
      end

      // ---- DATA every 4 cycles, then a replay episode ----
      do_reset();
      link_up = 1; cyc();
      user_vld = 1;
      for (int i = 0; i < 6; i++) begin
         frame_slot = 1; cyc(); chk("p4_user_rdy_slot", s_urdy, 1);
         frame_slot = 0; cyc(); chk("p4_ftv", s_ftv, 1); chk("p4_ft", s_ft, 1);
         chk("p4_user_rdy_gap", s_urdy, 0);
         cyc(); cyc(); chk("p4_ftv_off", s_ftv, 0);
      end
      retrans_req = 1; cyc();
      retrans_req = 0; cyc(); chk("rp_rewind", s_rew, 1);
      cyc(); chk("rp_rewind_once", s_rew, 0);
      replay_vld = 1;
      for (int i = 0; i < 3; i++) begin
         do_slot(); chk("rp_ft_replay", slot_ft, 2);
         chk("rp_user_rdy", slot_urdy, 0); chk("rp_replay_rd", slot_rrd, 1);
      end
      replay_vld = 0;
      do_slot(); chk("rp_ft_idle", slot_ft, 0);
      do_slot(); chk("rp_ft_data_after", slot_ft, 1);

      // ---- rx_error holdoff merge ----
      do_reset();
      link_up = 1; user_vld = 1; cyc();
      cnt = 0;
      for (int i = 0; i < 26; i++) begin
         rx_error = (i == 0 || i == 5 || i == 20);
         do_slot();
         exp_ft = (i == 1 || i == 21) ? 4 : 1;
         chk($sformatf("hold_slot%0d", i), slot_ft, exp_ft);
         if (slot_ft == 4) cnt++;
      end
      chk("hold_rtx_count", cnt, 2);

      // ---- pause refresh with coincident rx_error ----
      do_reset();
      link_up = 1; user_vld = 1; cyc();
      cnt = 0;
      for (int i = 0; i < 155; i++) begin
         rx_up = (i >= 150);
         rx_error = (i == 64);
         do_slot();
         if (i == 1 || i == 66 || i == 129) exp_ft = 3;
         else if (i == 65) exp_ft = 4;
         else exp_ft = 1;
         chk($sformatf("pause_slot%0d", i), slot_ft, exp_ft);
         if (slot_ft == 3) cnt++;
      end
      chk("pause_count", cnt, 3);

      // ---- pause_req blocks data ----
      do_reset();
      link_up = 1; user_vld = 1; cyc();
      pause_req = 1;
      for (int i = 0; i < 3; i++) begin
         do_slot(); chk("preq_ft_idle", slot_ft, 0); chk("preq_user_rdy", slot_urdy, 0);
      end
      pause_req = 0;
      do_slot(); chk("preq_ft_data", slot_ft, 1); chk("preq_user_rdy_back", slot_urdy, 1);

      // ---- link drop in REPLAY with rtx_pend ----
      do_reset();
      link_up = 1; user_vld = 1; cyc();
      retrans_req = 1; cyc();
      retrans_req = 0; cyc(); chk("ld_rewind", s_rew, 1);
      replay_vld = 1; rx_error = 1;
      do_slot(); chk("ld_replay_rd", slot_rrd, 1);
      link_up = 0; frame_slot = 1; cyc();
      chk("ld_rd_now", s_rrd, 0); chk("ld_urdy_now", s_urdy, 0);
      for (int i = 0; i < 6; i++) begin
         frame_slot = (i % 2 == 1);
         cyc();
         if (i == 0) chk("ld_ft_idle_now", s_ft, 0);
         chk("ld_rewind_off", s_rew, 0); chk("ld_rd_off", s_rrd, 0);
      end
      frame_slot = 0; link_up = 1; cyc();
      for (int i = 0; i < 5; i++) begin
         do_slot(); chk("ld_no_stale_rtx", slot_ft, 1);
      end

      // ---- randomized run against the model ----
      do_reset();
      link_up = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 2) link_up = ~link_up;
         if ($urandom_range(0, 99) < 3) rx_up = ~rx_up;
         if ($urandom_range(0, 99) < 5) pause_req = ~pause_req;
         frame_slot  = $urandom_range(0, 1);
         user_vld    = ($urandom_range(0, 3) != 0);
         replay_vld  = ($urandom_range(0, 3) != 0);
         retrans_req = ($urandom_range(0, 99) < 4);
         rx_error    = ($urandom_range(0, 99) < 5);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
